game_sequencer: RTL and testbench

Top-level Pac-Man game-flow controller. Sequences title screen, ready countdown, play, pause, death, level-clear and game-over phases from keyboard keycodes, collision and pellet status. Gates sprite motion, commands maze/sprite reloads, and tracks lives and level. Sits between the keyboard interface, the collision/pellet logic and the sprite movers.

---
 rtl/game_pkg.sv | 17 +
 rtl/game_sequencer_key_edge.sv | 34 +++
 rtl/game_sequencer.sv | 129 ++++++++++++
 tb/tb_game_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and key codes for the Pac-Man game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DYING = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6
  } game_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

endpackage

// File: rtl/game_sequencer_key_edge.sv
// Keycode edge detector: one registered press pulse per new SPACE / P keycode.
module key_edge
  import game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_keycode,
  output logic       o_space_press,
  output logic       o_p_press
);

  logic [7:0] r_key_prev;
  logic       r_space_press;
  logic       r_p_press;
  logic       w_key_changed;

  assign w_key_changed = (i_keycode != r_key_prev);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_key_prev    <= 8'h00;
      r_space_press <= 1'b0;
      r_p_press     <= 1'b0;
    end else begin
      r_key_prev    <= i_keycode;
      r_space_press <= w_key_changed && (i_keycode == KEY_SPACE);
      r_p_press     <= w_key_changed && (i_keycode == KEY_P);
    end
  end

  assign o_space_press = r_space_press;
  assign o_p_press     = r_p_press;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM: title, ready countdown, play, pause, death, level clear, game over.
module game_sequencer
  import game_pkg::*;
#(
  parameter int READY_FRAMES = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int CLEAR_FRAMES = 120,
  parameter int START_LIVES  = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       pac_hit,
  input  logic [7:0] dots_left,
  output logic       move_en,
  output logic       level_load,
  output logic       pos_reset,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [2:0] screen_sel
);

  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

  game_state_t r_state;
  logic [7:0]  r_frame_cnt;
  logic [1:0]  r_lives;
  logic [3:0]  r_level;
  logic        r_level_load;
  logic        r_pos_reset;

  logic w_space_press;
  logic w_p_press;
  logic w_cnt_en;

  key_edge u_key_edge (
    .i_clk         (Clk),
    .i_reset       (Reset),
    .i_keycode     (keycode),
    .o_space_press (w_space_press),
    .o_p_press     (w_p_press)
  );

  assign w_cnt_en = frame_tick &&
                    (r_state == READY || r_state == DYING || r_state == CLEAR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= TITLE;
      r_frame_cnt  <= 8'd0;
      r_lives      <= 2'd0;
      r_level      <= 4'd0;
      r_level_load <= 1'b0;
      r_pos_reset  <= 1'b0;
    end else begin
      r_level_load <= 1'b0;
      r_pos_reset  <= 1'b0;
      if (w_cnt_en) r_frame_cnt <= r_frame_cnt + 8'd1;
      // Every transition below also clears the frame counter (overrides the increment).
      unique case (r_state)
        TITLE: if (w_space_press) begin
          r_lives      <= LIVES_INIT;
          r_level      <= 4'd1;
          r_level_load <= 1'b1;
          r_pos_reset  <= 1'b1;
          r_frame_cnt  <= 8'd0;
          r_state      <= READY;
        end
        READY: if (frame_tick && r_frame_cnt == READY_LAST) begin
          r_frame_cnt <= 8'd0;
          r_state     <= PLAY;
        end
        PLAY: begin
          if (dots_left == 8'd0) begin
            r_frame_cnt <= 8'd0;
            r_state     <= CLEAR;
          end else if (pac_hit) begin
            r_frame_cnt <= 8'd0;
            r_state     <= DYING;
          end else if (w_p_press) begin
            r_frame_cnt <= 8'd0;
            r_state     <= PAUSE;
          end
        end
        PAUSE: if (w_p_press) begin
          r_frame_cnt <= 8'd0;
          r_state     <= PLAY;
        end
        DYING: if (frame_tick && r_frame_cnt == DEATH_LAST) begin
          r_frame_cnt <= 8'd0;
          r_lives     <= r_lives - 2'd1;
          if (r_lives == 2'd1) begin
            r_state <= OVER;
          end else begin
            r_pos_reset <= 1'b1;
            r_state     <= READY;
          end
        end
        CLEAR: if (frame_tick && r_frame_cnt == CLEAR_LAST) begin
          r_frame_cnt  <= 8'd0;
          r_level      <= (r_level == 4'd15) ? 4'd15 : r_level + 4'd1;
          r_level_load <= 1'b1;
          r_pos_reset  <= 1'b1;
          r_state      <= READY;
        end
        OVER: if (w_space_press) begin
          r_frame_cnt <= 8'd0;
          r_state     <= TITLE;
        end
        default: begin
          r_frame_cnt <= 8'd0;
          r_state     <= TITLE;
        end
      endcase
    end
  end

  assign move_en    = (r_state == PLAY);
  assign screen_sel = r_state;
  assign level_load = r_level_load;
  assign pos_reset  = r_pos_reset;
  assign lives      = r_lives;
  assign level      = r_level;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a vector table plus hand-written multi-cycle sequences.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int RF = 4;
  localparam int DF = 3;
  localparam int CF = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       pac_hit = 1'b0;
  logic [7:0] dots_left = 8'd10;
  logic       move_en, level_load, pos_reset;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] screen_sel;

  int n_pass = 0;
  int n_total = 0;

  game_sequencer #(
    .READY_FRAMES(RF), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF), .START_LIVES(3)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .pac_hit(pac_hit), .dots_left(dots_left), .move_en(move_en),
    .level_load(level_load), .pos_reset(pos_reset), .lives(lives),
    .level(level), .screen_sel(screen_sel)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic       tick;
    logic       hit;
    logic [7:0] dots;
    logic [2:0] st;
    logic       ll;
    logic       pr;
    logic [1:0] lv;
    logic [3:0] lvl;
  } vec_t;

  vec_t tbl[$];

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic [7:0] k, input logic t, input logic h, input logic [7:0] d);
    keycode = k; frame_tick = t; pac_hit = h; dots_left = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic ll, input logic pr,
                     input logic [1:0] lv, input logic [3:0] lvl);
    logic exp_mv;
    exp_mv = (st == 3'd2);
    n_total++;
    if (screen_sel !== st || move_en !== exp_mv || level_load !== ll ||
        pos_reset !== pr || lives !== lv || level !== lvl)
      $display("FAIL %s: got st=%0d mv=%0b ll=%0b pr=%0b lives=%0d level=%0d, want st=%0d mv=%0b ll=%0b pr=%0b lives=%0d level=%0d",
               nm, screen_sel, move_en, level_load, pos_reset, lives, level,
               st, exp_mv, ll, pr, lv, lvl);
    else
      n_pass++;
  endtask

  task automatic ready_to_play();
    for (int i = 0; i < RF; i++) cyc(8'h00, 1'b1, 1'b0, 8'd10);
  endtask

  task automatic start_game();
    cyc(8'h00, 1'b0, 1'b0, 8'd10);
    cyc(KEY_SPACE, 1'b0, 1'b0, 8'd10);
    cyc(KEY_SPACE, 1'b0, 1'b0, 8'd10);
    keycode = 8'h00;
  endtask

  initial begin
    //             rst key        tk hit dots | st ll pr lv lvl
    tbl.push_back('{1'b1, 8'h00,     1'b0, 1'b0, 8'd10, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0});
    tbl.push_back('{1'b0, 8'h00,     1'b0, 1'b0, 8'd10, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b0, 1'b0, 8'd10, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b0, 1'b0, 8'd10, 3'd1, 1'b1, 1'b1, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b1, 1'b0, 8'd10, 3'd1, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b0, 1'b0, 8'd10, 3'd1, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b1, 1'b0, 8'd10, 3'd1, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b1, 1'b0, 8'd10, 3'd1, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b1, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b1, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_SPACE, 1'b0, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b0, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_P,     1'b0, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_P,     1'b0, 1'b0, 8'd10, 3'd3, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_P,     1'b1, 1'b1, 8'd10, 3'd3, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b1, 1'b1, 8'd0,  3'd3, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_P,     1'b0, 1'b0, 8'd10, 3'd3, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, KEY_P,     1'b0, 1'b0, 8'd10, 3'd2, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b0, 1'b1, 8'd0,  3'd5, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b1, 1'b0, 8'd10, 3'd5, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b0, 1'b1, 8'd10, 3'd5, 1'b0, 1'b0, 2'd3, 4'd1});
    tbl.push_back('{1'b0, 8'h00,     1'b1, 1'b0, 8'd10, 3'd1, 1'b1, 1'b1, 2'd3, 4'd2});
    tbl.push_back('{1'b0, 8'h00,     1'b0, 1'b0, 8'd10, 3'd1, 1'b0, 1'b0, 2'd3, 4'd2});

    foreach (tbl[i]) begin
      Reset = tbl[i].rst;
      cyc(tbl[i].key, tbl[i].tick, tbl[i].hit, tbl[i].dots);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].ll, tbl[i].pr, tbl[i].lv, tbl[i].lvl);
    end

    // Two deaths back to READY, then the last life ends in OVER.
    for (int d = 0; d < 2; d++) begin
      ready_to_play();
      chk("die_play", 3'd2, 1'b0, 1'b0, 2'(3 - d), 4'd2);
      cyc(8'h00, 1'b0, 1'b1, 8'd10);
      chk("die_enter", 3'd4, 1'b0, 1'b0, 2'(3 - d), 4'd2);
      for (int i = 0; i < DF - 1; i++) cyc(8'h00, 1'b1, 1'b0, 8'd10);
      chk("die_wait", 3'd4, 1'b0, 1'b0, 2'(3 - d), 4'd2);
      cyc(8'h00, 1'b1, 1'b0, 8'd10);
      chk("die_ready", 3'd1, 1'b0, 1'b1, 2'(2 - d), 4'd2);
    end
    ready_to_play();
    cyc(8'h00, 1'b0, 1'b1, 8'd10);
    for (int i = 0; i < DF; i++) cyc(8'h00, 1'b1, 1'b0, 8'd10);
    chk("over_enter", 3'd6, 1'b0, 1'b0, 2'd0, 4'd2);
    cyc(8'h00, 1'b1, 1'b1, 8'd0);
    chk("over_hold", 3'd6, 1'b0, 1'b0, 2'd0, 4'd2);
    cyc(KEY_SPACE, 1'b0, 1'b0, 8'd10);
    cyc(KEY_SPACE, 1'b0, 1'b0, 8'd10);
    chk("over_title", 3'd0, 1'b0, 1'b0, 2'd0, 4'd2);

    // Reset in the middle of a death animation.
    start_game();
    chk("restart", 3'd1, 1'b1, 1'b1, 2'd3, 4'd1);
    ready_to_play();
    cyc(8'h00, 1'b0, 1'b1, 8'd10);
    cyc(8'h00, 1'b1, 1'b0, 8'd10);
    chk("mid_dying", 3'd4, 1'b0, 1'b0, 2'd3, 4'd1);
    Reset = 1'b1;
    cyc(8'h00, 1'b1, 1'b0, 8'd10);
    chk("reset_mid", 3'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    Reset = 1'b0;

    // Twenty level clears: level climbs and saturates at 15.
    start_game();
    for (int n = 0; n < 20; n++) begin
      ready_to_play();
      cyc(8'h00, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < CF; i++) cyc(8'h00, 1'b1, 1'b0, 8'd10);
      chk($sformatf("clear%0d", n), 3'd1, 1'b1, 1'b1, 2'd3, 4'((n + 2 > 15) ? 15 : n + 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
